// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial converter with valid/ready load and done pulse.
// Define SER_PARITY_EN to append an even-parity bit after the data bits.
module bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic par_q, par_d;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign load_ready = (state_q == IDLE);
    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // shreg holds the bits still to be sent, next one at the MSB
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: if (load_valid) begin
                state_d     = SHIFT;
                shreg_d     = load_data << 1;
                cnt_d       = '0;
                ser_out_d   = load_data[WIDTH-1];
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
`ifdef SER_PARITY_EN
                par_d       = ^load_data;
`endif
            end
            SHIFT: if (shift_en) begin
                if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SER_PARITY_EN
                    state_d     = PAR;
                    ser_out_d   = par_q;
`else
                    state_d     = IDLE;
                    ser_out_d   = IDLE_LEVEL;
                    ser_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
`endif
                end else begin
                    shreg_d   = shreg_q << 1;
                    ser_out_d = shreg_q[WIDTH-1];
                    cnt_d     = cnt_q + 1'b1;
                end
            end
`ifdef SER_PARITY_EN
            PAR: if (shift_en) begin
                state_d     = IDLE;
                ser_out_d   = IDLE_LEVEL;
                ser_valid_d = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed self-checking bench for bit_serializer (WIDTH=8, IDLE_LEVEL=0).
module tb_bit_serializer;
`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_ready;
    logic       shift_en = 1'b1;
    logic       ser_out, ser_valid, busy, done;
    int         errors = 0;
    int         checks = 0;

    bit_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .shift_en(shift_en), .ser_out(ser_out),
        .ser_valid(ser_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // frame bit idx: data MSB-first, then parity at idx 8
    function automatic logic fbit(input logic [7:0] w, input int idx);
        logic [7:0] t;
        t = w;
        return (idx == 8) ? ^t : t[7-idx];
    endfunction

    task automatic send(input logic [7:0] w);
        check("load_ready_pre", load_ready, 1);
        load_valid = 1'b1;
        load_data  = w;
        step();
        load_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] w, input string tag);
        send(w);
        for (int i = 0; i < NB; i++) begin
            check({tag, "_bit"}, ser_out, fbit(w, i));
            check({tag, "_valid"}, ser_valid, 1);
            check({tag, "_done"}, done, 0);
            step();
        end
        check({tag, "_done_end"}, done, 1);
        check({tag, "_idle_out"}, ser_out, 0);
        check({tag, "_valid_end"}, ser_valid, 0);
        check({tag, "_busy_end"}, busy, 0);
        step();
        check({tag, "_done_once"}, done, 0);
    endtask

    initial begin
        load_valid = 1'b1;
        load_data  = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_valid", ser_valid, 0);
            check("rst_out", ser_out, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end
        reset = 1'b1;
        load_valid = 1'b0;
        check("rst_ready", load_ready, 1);
        step();
        check("rst_noaccept", ser_valid, 0);

        frame(8'hA5, "a5");

        send(8'hA5);
        for (int c = 1; c <= NB + 2; c++) begin
            int b;
            b = (c <= 4) ? c - 1 : (c <= 6) ? 3 : c - 3;
            check("stall_bit", ser_out, fbit(8'hA5, b));
            check("stall_valid", ser_valid, 1);
            check("stall_done", done, 0);
            shift_en = !(c == 4 || c == 5);
            step();
        end
        check("stall_done_end", done, 1);
        check("stall_valid_end", ser_valid, 0);
        step();

        send(8'hF0);
        for (int c = 1; c <= NB; c++) begin
            if (c >= 2) check("ign_ready", load_ready, 0);
            check("ign_bit", ser_out, fbit(8'hF0, c - 1));
            load_valid = (c >= 2 && c <= 5);
            load_data  = 8'h0F;
            step();
        end
        check("b2b_done", done, 1);
        check("b2b_ready", load_ready, 1);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            check("b2b_bit", ser_out, fbit(8'h0F, i));
            check("b2b_valid", ser_valid, 1);
            step();
        end
        check("b2b_done2", done, 1);
        step();

        send(8'hFF);
        for (int c = 1; c <= 4; c++) begin
            check("abort_bit", ser_out, 1);
            step();
        end
        reset = 1'b0;
        step();
        check("abort_valid", ser_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_out", ser_out, 0);
        check("abort_done", done, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_nodone", done, 0);
            check("abort_idle", ser_valid, 0);
        end

`ifdef SER_PARITY_EN
        frame(8'h07, "par07");
        frame(8'h03, "par03");
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
